display_scan: RTL and testbench

DISPLAY_SCAN -- requirements
Module: display_scan

---
 rtl/disp_pkg.sv | 14 +
 rtl/tick_gen.sv | 23 ++
 rtl/display_scan.sv | 87 ++++++++
 tb/tb_display_scan.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared types and helpers for the multiplexed 4-digit display scanner.
package disp_pkg;

  localparam int NUM_DIGITS = 4;

  typedef logic [$clog2(NUM_DIGITS)-1:0] digit_idx_t;
  typedef logic [NUM_DIGITS-1:0]         anode_t;

  // Active-low anode pattern with only the selected digit driven low.
  function automatic anode_t one_cold(input digit_idx_t idx);
    return ~(anode_t'(1) << idx);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler 0..DIV-1; tick is registered and high while count == DIV-1.
module tick_gen #(
  parameter  int DIV = 4,
  localparam int CW  = $clog2(DIV)
) (
  input  logic          clk,
  input  logic          rst,
  output logic [CW-1:0] count,
  output logic          tick
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      tick  <= 1'b0;
    end else begin
      count <= (count == CW'(DIV - 1)) ? '0 : count + 1'b1;
      // Raised one cycle early so the registered pulse lines up with count == DIV-1.
      tick  <= (count == CW'(DIV - 2));
    end
  end

endmodule

// File: rtl/display_scan.sv
// Four-digit display scanner with dead-time blanking and per-digit masking.
// Optional whole-display blinking is enabled by defining DISPLAY_SCAN_BLINK_EN.
module display_scan
  import disp_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int DEAD_CYC    = 500,
  parameter int BLINK_DIV   = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] digit_mask,
  input  logic       blink,
  output logic       sel,
  output logic       nib,
  output anode_t     an,
  output logic       tick
);

  localparam int CW = $clog2(REFRESH_DIV);

  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  digit_idx_t    idx;
  digit_idx_t    idx_nxt;
  logic          blink_off;
  logic          lit;

  tick_gen #(.DIV(REFRESH_DIV)) u_tick_gen (
    .clk   (clk),
    .rst   (rst),
    .count (count),
    .tick  (tick)
  );

  // NOTE: outputs are registered from next-cycle values so every output lines up
  // with the prescaler and index it describes, without any combinational path out.
  always_comb begin
    count_nxt = tick ? '0 : count + 1'b1;
    idx_nxt   = tick ? idx + 1'b1 : idx;
    lit       = digit_mask[idx_nxt] && (int'(count_nxt) >= DEAD_CYC) && !blink_off;
  end

`ifdef DISPLAY_SCAN_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BW-1:0] blink_cnt;
  logic          phase;
  logic          blink_wrap;
  logic          phase_nxt;

  always_comb begin
    blink_wrap = tick && (blink_cnt == BW'(BLINK_DIV - 1));
    phase_nxt  = blink_wrap ? ~phase : phase;
    blink_off  = blink && phase_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (tick) begin
      blink_cnt <= blink_wrap ? '0 : blink_cnt + 1'b1;
      phase     <= phase_nxt;
    end
  end
`else
  logic unused_blink;
  assign unused_blink = blink;
  assign blink_off    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
      sel <= 1'b0;
      nib <= 1'b0;
      an  <= '1;
    end else begin
      idx <= idx_nxt;
      sel <= idx_nxt[1];
      nib <= idx_nxt[0];
      an  <= lit ? one_cold(idx_nxt) : '1;
    end
  end

endmodule

// File: tb/tb_display_scan.sv
// Self-checking bench for display_scan against a cycle-count reference model.
// Build with DISPLAY_SCAN_BLINK_EN defined to exercise the blink feature.
module tb_display_scan;

  localparam int REFRESH_DIV = 4;
  localparam int DEAD_CYC    = 1;
  localparam int BLINK_DIV   = 2;
`ifdef DISPLAY_SCAN_BLINK_EN
  localparam bit BLINK_EN = 1'b1;
`else
  localparam bit BLINK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] digit_mask = 4'hF;
  logic       blink = 1'b0;
  logic       sel;
  logic       nib;
  logic [3:0] an;
  logic       tick;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: t = clock edges since the last reset edge.
  int         t = 0;
  logic [6:0] exp_out;  // {tick, sel, nib, an}

  always #5 clk = ~clk;

  display_scan #(
    .REFRESH_DIV (REFRESH_DIV),
    .DEAD_CYC    (DEAD_CYC),
    .BLINK_DIV   (BLINK_DIV)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .digit_mask (digit_mask),
    .blink      (blink),
    .sel        (sel),
    .nib        (nib),
    .an         (an),
    .tick       (tick)
  );

  // Advance one clock, update the model with the inputs seen at that edge, then settle.
  task automatic cycle();
    logic [3:0] m;
    logic       b;
    logic       r;
    int         p;
    int         w;
    int         d;
    bit         off;
    bit         lit;
    logic [3:0] ea;
    m = digit_mask;
    b = blink;
    r = rst;
    @(posedge clk);
    if (r) t = 0;
    else   t = t + 1;
    p   = t % REFRESH_DIV;
    w   = t / REFRESH_DIV;
    d   = w % 4;
    off = BLINK_EN && b && (((w / BLINK_DIV) % 2) == 1);
    lit = !r && m[d] && (p >= DEAD_CYC) && !off;
    for (int k = 0; k < 4; k++) ea[k] = !(lit && (k == d));
    exp_out = {(!r && (p == REFRESH_DIV - 1)), (!r && (d / 2 == 1)), (!r && (d % 2 == 1)), ea};
    #1;
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    digit_mask = 4'hF;
    blink      = 1'b0;
    repeat (3) begin
      cycle();
      n_checks++;
      if (an !== 4'b1111) begin
        n_fail++;
        $display("FAIL reset_an: got %b required 1111", an);
      end
      n_checks++;
      if (sel !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_sel: got %b required 0", sel);
      end
      n_checks++;
      if (nib !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_nib: got %b required 0", nib);
      end
      n_checks++;
      if (tick !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_tick: got %b required 0", tick);
      end
    end
  endtask

  task automatic test_scan_order();
    logic [3:0] an_seq [8];
    an_seq = '{4'b1110, 4'b1110, 4'b1110, 4'b1111, 4'b1101, 4'b1101, 4'b1101, 4'b1111};
    rst = 1'b0;
    for (int i = 0; i < 24; i++) begin
      cycle();
      n_checks++;
      if ({tick, sel, nib, an} !== exp_out) begin
        n_fail++;
        $display("FAIL scan_order t=%0d: got tick/sel/nib/an=%b required %b", t, {tick, sel, nib, an}, exp_out);
      end
      if (i < 8) begin
        n_checks++;
        if (an !== an_seq[i]) begin
          n_fail++;
          $display("FAIL scan_order_table t=%0d: got an=%b required %b", t, an, an_seq[i]);
        end
      end
    end
  endtask

  task automatic test_masking();
    digit_mask = 4'b0101;
    for (int i = 0; i < 20; i++) begin
      cycle();
      n_checks++;
      if ({tick, sel, nib, an} !== exp_out) begin
        n_fail++;
        $display("FAIL masking t=%0d: got tick/sel/nib/an=%b required %b", t, {tick, sel, nib, an}, exp_out);
      end
    end
    digit_mask = 4'hF;
  endtask

  task automatic test_mid_reset();
    int budget;
    int waited;
    budget = 0;
    while (!(((t / REFRESH_DIV) % 4 == 2) && (t % REFRESH_DIV == 1)) && budget < 32) begin
      cycle();
      budget++;
    end
    n_checks++;
    if (budget >= 32) begin
      n_fail++;
      $display("FAIL mid_reset_reach: digit 2 window not reached within 32 cycles");
    end
    rst = 1'b1;
    cycle();
    n_checks++;
    if ({sel, nib, an} !== 6'b00_1111) begin
      n_fail++;
      $display("FAIL mid_reset_abort: got sel/nib/an=%b required 001111", {sel, nib, an});
    end
    rst    = 1'b0;
    waited = 0;
    do begin
      cycle();
      waited++;
      n_checks++;
      if ({tick, sel, nib, an} !== exp_out) begin
        n_fail++;
        $display("FAIL mid_reset_resume t=%0d: got tick/sel/nib/an=%b required %b", t, {tick, sel, nib, an}, exp_out);
      end
    end while (an === 4'b1111 && waited < 8);
    n_checks++;
    if (waited != 1 || an !== 4'b1110) begin
      n_fail++;
      $display("FAIL mid_reset_first_lit: lit after %0d cycles with an=%b required 1 cycle with 1110", waited, an);
    end
  endtask

  task automatic test_blink();
    rst = 1'b1;
    cycle();
    rst   = 1'b0;
    blink = 1'b1;
    for (int i = 0; i < 40; i++) begin
      cycle();
      n_checks++;
      if ({tick, sel, nib, an} !== exp_out) begin
        n_fail++;
        $display("FAIL blink_on t=%0d: got tick/sel/nib/an=%b required %b", t, {tick, sel, nib, an}, exp_out);
      end
    end
    blink = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      n_checks++;
      if ({tick, sel, nib, an} !== exp_out) begin
        n_fail++;
        $display("FAIL blink_off t=%0d: got tick/sel/nib/an=%b required %b", t, {tick, sel, nib, an}, exp_out);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      digit_mask = 4'($urandom);
      if ($urandom_range(0, 9) == 0) blink = 1'($urandom);
      rst = ($urandom_range(0, 49) == 0);
      cycle();
      n_checks++;
      if ({tick, sel, nib, an} !== exp_out) begin
        n_fail++;
        $display("FAIL random t=%0d: got tick/sel/nib/an=%b required %b", t, {tick, sel, nib, an}, exp_out);
      end
      n_checks++;
      if ($countones(~an) > 1) begin
        n_fail++;
        $display("FAIL random_one_cold t=%0d: got an=%b required at most one low bit", t, an);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scan_order();
    test_masking();
    test_mid_reset();
    test_blink();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
